commit_stage: RTL

//  Writeback end of the operand-fetch channel/accumulator protocol. Execution branches finish out of order;

---
 rtl/commit_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/commit_stage.sv
// Reorder-buffered commit stage: accepts out-of-order branch results and retires them
// in commit_id order as channel/accumulator write pulses, with priority for the channel-0 sample write.
module commit_stage #(
  parameter int data_width = 16,
  parameter int n_branches = 4,
  parameter int rob_depth  = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               sample_tick,
  input  logic [data_width-1:0]              sample_in,
  input  logic [n_branches-1:0]              in_valid,
  output logic [n_branches-1:0]              in_ready,
  input  logic [9*n_branches-1:0]            commit_id_in,
  input  logic [4*n_branches-1:0]            dest_in,
  input  logic [n_branches-1:0]              writes_accumulator_in,
  input  logic [data_width*n_branches-1:0]   result_in,
  input  logic [2*data_width*n_branches-1:0] acc_result_in,
  output logic                               channel_write_enable,
  output logic [3:0]                         channel_write_addr,
  output logic [data_width-1:0]              channel_write_val,
  output logic                               accumulator_write_enable,
  output logic [2*data_width-1:0]            accumulator_write_val,
  output logic [8:0]                         head_id
);

  localparam int         SW    = $clog2(rob_depth);
  localparam logic [9:0] DEPTH = 10'(rob_depth);

  logic [rob_depth-1:0]    r_valid;
  logic [3:0]              r_dest   [rob_depth];
  logic                    r_wacc   [rob_depth];
  logic [data_width-1:0]   r_res    [rob_depth];
  logic [2*data_width-1:0] r_acc    [rob_depth];

  logic [8:0]              r_head;
  logic                    r_pending;
  logic [data_width-1:0]   r_sample;
  logic                    r_ch_we;
  logic [3:0]              r_ch_addr;
  logic [data_width-1:0]   r_ch_val;
  logic                    r_acc_we;
  logic [2*data_width-1:0] r_acc_val;

  logic [8:0]    w_id   [n_branches];
  logic [8:0]    w_diff [n_branches];
  logic [SW-1:0] w_slot [n_branches];
  logic [SW-1:0] w_hslot;

  assign w_hslot = r_head[SW-1:0];

  // Window test is modulo 512: ids behind head wrap to large differences and are refused.
  for (genvar b = 0; b < n_branches; b++) begin : g_ready
    assign w_id[b]     = commit_id_in[9*b +: 9];
    assign w_diff[b]   = w_id[b] - r_head;
    assign w_slot[b]   = w_id[b][SW-1:0];
    assign in_ready[b] = enable & in_valid[b] & ({1'b0, w_diff[b]} < DEPTH) & ~r_valid[w_slot[b]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= '0;
      r_head    <= '0;
      r_pending <= 1'b0;
      r_sample  <= '0;
      r_ch_we   <= 1'b0;
      r_ch_addr <= '0;
      r_ch_val  <= '0;
      r_acc_we  <= 1'b0;
      r_acc_val <= '0;
    end else begin
      r_ch_we  <= 1'b0;
      r_acc_we <= 1'b0;
      if (enable) begin
        if (r_pending) begin
          r_ch_we   <= 1'b1;
          r_ch_addr <= '0;
          r_ch_val  <= r_sample;
          r_pending <= 1'b0;
        end else if (r_valid[w_hslot]) begin
          if (r_wacc[w_hslot]) begin
            r_acc_we  <= 1'b1;
            r_acc_val <= r_acc[w_hslot];
          end else begin
            r_ch_we   <= 1'b1;
            r_ch_addr <= r_dest[w_hslot];
            r_ch_val  <= r_res[w_hslot];
          end
          r_valid[w_hslot] <= 1'b0;
          r_head           <= r_head + 9'd1;
        end
        // A tick arriving as the previous sample drains keeps the new one pending.
        if (sample_tick) begin
          r_pending <= 1'b1;
          r_sample  <= sample_in;
        end
        for (int unsigned b = 0; b < n_branches; b++) begin
          if (in_ready[b]) r_valid[w_slot[b]] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < n_branches; b++) begin
      if (in_ready[b]) begin
        r_dest[w_slot[b]] <= dest_in[4*b +: 4];
        r_wacc[w_slot[b]] <= writes_accumulator_in[b];
        r_res[w_slot[b]]  <= result_in[data_width*b +: data_width];
        r_acc[w_slot[b]]  <= acc_result_in[2*data_width*b +: 2*data_width];
      end
    end
  end

  assign channel_write_enable     = r_ch_we;
  assign channel_write_addr       = r_ch_addr;
  assign channel_write_val        = r_ch_val;
  assign accumulator_write_enable = r_acc_we;
  assign accumulator_write_val    = r_acc_val;
  assign head_id                  = r_head;

endmodule
